soda_datapath: RTL and testbench
================================

Name: soda_datapath

Overview:
- Datapath for a coin-operated soda dispenser.
- Accumulates inserted coin values in a running-total register (tot).
- Continuously compares tot against the soda price.
- Driven by an external controller FSM through load/clear strobes; returns a single status flag tot_lt_s to that controller.

Parameters:
- WIDTH, 8, bit width of price, coin value and running total.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset; clears tot.
- s  input  WIDTH  soda price, unsigned; treated as a live combinational input, not registered.
- a  input  WIDTH  value of the coin currently presented, unsigned.
- tot_ld  input  1  load strobe; adds a into tot on the next rising edge.
- tot_clr  input  1  clear strobe; zeroes tot on the next rising edge.
- tot_lt_s  output  1  combinational flag, 1 when tot < s (unsigned compare).
- tot  output  WIDTH  current running total, for debug/visibility.

Behaviour:
- State: one WIDTH-bit register tot.
- Update priority at each rising clk edge, highest first:
  1. rst=1 → tot <= 0.
  2. tot_clr=1 → tot <= 0.
  3. tot_ld=1 → tot <= tot + a.
  4. otherwise → tot holds.
- tot_clr beats tot_ld when both are asserted in the same cycle: result is 0, and a is not added.
- Addition is unsigned, modulo 2^WIDTH. Overflow wraps with no saturation and no carry output; the controller prevents overflow in normal use.
- tot_ld is level-sensitive: one add per rising edge while high. Holding it high N edges adds a N times. The controller must pulse it for exactly one cycle per coin.
- tot_lt_s = (tot < s), purely combinational from the tot register and the s input:
  - Updates in the same cycle s changes.
  - Updates after the clock edge that changes tot.
  - No extra pipeline latency.
- Latency: a load or clear is visible on tot and tot_lt_s immediately after the capturing rising edge (1-cycle latency from strobe to effect).
- Reset values: tot = 0, so tot_lt_s = (s != 0). With s = 0, tot_lt_s = 0.
- Boundaries:
  - tot == s → tot_lt_s = 0; the price is met.
  - tot > s → tot_lt_s = 0.
  - a = 0 with tot_ld → tot unchanged.
  - rst asserted mid-accumulation → tot = 0 on the next edge regardless of other strobes.
- No asynchronous behaviour; no internal FSM. Sequencing is owned by the controller.
- Inputs are assumed synchronous to clk.

Test Plan:
- Clear/reset: rst=1 for one edge, then s=60 → tot=0, tot_lt_s=1. Repeat using tot_clr instead of rst → same result.
- Accumulation below price: s=60; one-cycle tot_ld pulses with a=25, then a=10, then a=5 → tot=25, 35, 40 after each pulse; tot_lt_s=1 after each.
- Crossing price: from tot=40, pulse tot_ld with a=25 → tot=65, tot_lt_s=0. Then tot_clr pulse → tot=0, tot_lt_s=1.
- Exact match and priority: s=50, load 25 twice → tot=50, tot_lt_s=0. Next cycle assert tot_clr=1 and tot_ld=1 together with a=5 → tot=0 (clear wins), tot_lt_s=1.
- Wrap and hold: tot=250, load a=10 → tot=4 (mod 256), tot_lt_s=1 for s=60. With tot_ld held high 3 edges and a=5 from 0 → tot=15.
- Live price change: tot=40, s changed 60→30 with no clock edge → tot_lt_s falls 1→0 combinationally. s=40 → tot_lt_s=0. s=41 → tot_lt_s=1.

Source files
------------

// File: rtl/soda_datapath.sv
// soda_datapath: running-total datapath for a coin-operated soda dispenser.
// An external controller owns sequencing; this block only accumulates coins
// and reports whether the total is still below the price.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst      - synchronous active-high reset, clears tot
//   s        - soda price (unsigned, live combinational input)
//   a        - value of the coin currently presented (unsigned)
//   tot_ld   - load strobe, adds a into tot on the next rising edge
//   tot_clr  - clear strobe, zeroes tot on the next rising edge (beats tot_ld)
//   tot_lt_s - combinational flag, tot < s
//   tot      - current running total
module soda_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] a,
    input  logic             tot_ld,
    input  logic             tot_clr,
    output logic             tot_lt_s,
    output logic [WIDTH-1:0] tot
);

    logic [WIDTH-1:0] tot_q;
    logic [WIDTH-1:0] tot_d;

    // Next total: clear has priority over load; the add wraps modulo 2^WIDTH.
    always_comb begin
        tot_d = tot_q;
        if (tot_clr) begin
            tot_d = '0;
        end else if (tot_ld) begin
            tot_d = WIDTH'(tot_q + a);
        end
    end

    // Total register; reset dominates every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q <= '0;
        end else begin
            tot_q <= tot_d;
        end
    end

    // The price compare is left unregistered so a price change is seen
    // in the same cycle by the controller.
    assign tot      = tot_q;
    assign tot_lt_s = (tot_q < s);

endmodule

// File: tb/tb_soda_datapath.sv
// Self-checking bench for soda_datapath: an integer model of the running
// total is checked against the DUT after every rising edge, and directed
// literal expectations pin both the model and the DUT.
module tb_soda_datapath;

    logic       clk;
    logic       rst;
    logic [7:0] s;
    logic [7:0] a;
    logic       tot_ld;
    logic       tot_clr;
    logic       tot_lt_s;
    logic [7:0] tot;

    int checks   = 0;
    int failures = 0;

    int m_tot   = 0;
    bit m_valid = 1'b0;

    soda_datapath #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (s),
        .a        (a),
        .tot_ld   (tot_ld),
        .tot_clr  (tot_clr),
        .tot_lt_s (tot_lt_s),
        .tot      (tot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: reset/clear give zero, load adds coin value mod 256.
    always @(posedge clk) begin
        if (rst) begin
            m_tot   <= 0;
            m_valid <= 1'b1;
        end else if (tot_clr) begin
            m_tot <= 0;
        end else if (tot_ld) begin
            m_tot <= (m_tot + int'(a)) % 256;
        end
    end

    // Per-cycle comparison, sampled shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            checks++;
            if (int'(tot) != m_tot) begin
                failures++;
                $display("FAIL model_tot time=%0t actual=%0d expected=%0d", $time, tot, m_tot);
            end
            checks++;
            if (tot_lt_s !== (m_tot < int'(s))) begin
                failures++;
                $display("FAIL model_lt time=%0t actual=%0b expected=%0b tot=%0d s=%0d",
                         $time, tot_lt_s, (m_tot < int'(s)), tot, s);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then wait past the rising edge.
    task automatic step(input logic r, input logic ld, input logic clr,
                        input logic [7:0] av, input logic [7:0] sv);
        @(negedge clk);
        rst     = r;
        tot_ld  = ld;
        tot_clr = clr;
        a       = av;
        s       = sv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; tot_ld = 1'b0; tot_clr = 1'b0; a = 8'd0; s = 8'd60;

        // Reset, then clear, both give zero with tot below price.
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd60);
        check("rst_tot", int'(tot), 0);
        check("rst_lt", int'(tot_lt_s), 1);
        step(1'b0, 1'b1, 1'b0, 8'd9, 8'd60);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd60);
        check("clr_tot", int'(tot), 0);
        check("clr_lt", int'(tot_lt_s), 1);

        // Accumulation below price.
        step(1'b0, 1'b1, 1'b0, 8'd25, 8'd60);
        check("acc25", int'(tot), 25);
        step(1'b0, 1'b1, 1'b0, 8'd10, 8'd60);
        check("acc35", int'(tot), 35);
        step(1'b0, 1'b1, 1'b0, 8'd5, 8'd60);
        check("acc40", int'(tot), 40);
        check("acc40_lt", int'(tot_lt_s), 1);
        step(1'b0, 1'b0, 1'b0, 8'd77, 8'd60);
        check("hold40", int'(tot), 40);

        // Crossing the price, then clearing.
        step(1'b0, 1'b1, 1'b0, 8'd25, 8'd60);
        check("cross_tot", int'(tot), 65);
        check("cross_lt", int'(tot_lt_s), 0);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd60);
        check("cross_clr", int'(tot), 0);

        // Exact match, then clear beats load.
        step(1'b0, 1'b1, 1'b0, 8'd25, 8'd50);
        step(1'b0, 1'b1, 1'b0, 8'd25, 8'd50);
        check("match_tot", int'(tot), 50);
        check("match_lt", int'(tot_lt_s), 0);
        step(1'b0, 1'b1, 1'b1, 8'd5, 8'd50);
        check("prio_tot", int'(tot), 0);
        check("prio_lt", int'(tot_lt_s), 1);

        // Zero-value coin leaves the total unchanged.
        step(1'b0, 1'b1, 1'b0, 8'd30, 8'd50);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        check("zero_coin", int'(tot), 30);

        // Wraparound modulo 256.
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd60);
        step(1'b0, 1'b1, 1'b0, 8'd250, 8'd60);
        check("pre_wrap", int'(tot), 250);
        check("pre_wrap_lt", int'(tot_lt_s), 0);
        step(1'b0, 1'b1, 1'b0, 8'd10, 8'd60);
        check("wrap_tot", int'(tot), 4);
        check("wrap_lt", int'(tot_lt_s), 1);

        // Load held high for three edges adds three times.
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd60);
        step(1'b0, 1'b1, 1'b0, 8'd5, 8'd60);
        step(1'b0, 1'b1, 1'b0, 8'd5, 8'd60);
        step(1'b0, 1'b1, 1'b0, 8'd5, 8'd60);
        check("held_ld", int'(tot), 15);

        // Reset mid-accumulation wins over load.
        step(1'b1, 1'b1, 1'b0, 8'd7, 8'd60);
        check("rst_mid", int'(tot), 0);

        // Live price change with no clock edge.
        step(1'b0, 1'b1, 1'b0, 8'd40, 8'd60);
        check("live_tot", int'(tot), 40);
        check("live_lt60", int'(tot_lt_s), 1);
        @(negedge clk);
        tot_ld = 1'b0;
        s = 8'd30;
        #1 check("live_lt30", int'(tot_lt_s), 0);
        s = 8'd40;
        #1 check("live_lt40", int'(tot_lt_s), 0);
        s = 8'd41;
        #1 check("live_lt41", int'(tot_lt_s), 1);

        // Zero price with zero total.
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        check("s0_lt", int'(tot_lt_s), 0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
